// File: rtl/hamming_secded_decoder_if.sv
// Valid/ready bus of the SECDED decoder: codeword in,
// decoded data plus error flags out.
interface hamming_secded_decoder_if #(
   parameter int DATA_W = 4,
   parameter int PAR_W  = 3
);
   localparam int CW = DATA_W + PAR_W + 1;

   logic              in_valid;
   logic              in_ready;
   logic [CW-1:0]     in_cw;
   logic              correct_en;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              err_single;
   logic              err_double;

   modport master (
      output in_valid, in_cw, correct_en, out_ready,
      input  in_ready, out_valid, out_data,
      input  err_single, err_double
   );

   modport slave (
      input  in_valid, in_cw, correct_en, out_ready,
      output in_ready, out_valid, out_data,
      output err_single, err_double
   );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Extended-Hamming SECDED decoder: 2-stage pipeline with
// valid/ready flow control and saturating error counters.
module hamming_secded_decoder #(
   parameter int DATA_W = 4,
   parameter int PAR_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hamming_secded_decoder_if.slave bus,
   input  logic                    cnt_clr,
   output logic [CNT_W-1:0]        cnt_corr,
   output logic [CNT_W-1:0]        cnt_uncorr
);
   localparam int CW = DATA_W + PAR_W + 1;

   function automatic logic [PAR_W-1:0] syndrome(
      input logic [CW-1:0] cw
   );
      logic [PAR_W-1:0] s;
      s = '0;
      for (int i = 1; i < CW; i++) begin
         if (cw[i]) s = s ^ PAR_W'(i);
      end
      return s;
   endfunction

   // Data bits fill non-power-of-two positions in
   // ascending order; shifting in from the top lands
   // the first one at bit 0.
   function automatic logic [DATA_W-1:0] extract(
      input logic [CW-1:0] cw
   );
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 1; i < CW; i++) begin
         if ((i & (i - 1)) != 0) begin
            d = (d >> 1) | (DATA_W'(cw[i]) << (DATA_W - 1));
         end
      end
      return d;
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [CW-1:0]     cw_q, cw_d;
   logic [PAR_W-1:0]  syn_q, syn_d;
   logic              par_q, par_d;
   logic              ce_q, ce_d;

   logic              ov_q, ov_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              es_q, es_d;
   logic              ed_q, ed_d;

   logic [CNT_W-1:0]  corr_q, corr_d;
   logic [CNT_W-1:0]  uncorr_q, uncorr_d;

   logic              adv1, adv2, hs;
   logic              single, dbl;
   logic [CW-1:0]     fixed;

   assign adv2 = !ov_q || bus.out_ready;
   assign adv1 = !s1_valid_q || adv2;
   assign hs   = ov_q && bus.out_ready;

   assign bus.in_ready   = adv1 && rst_n;
   assign bus.out_valid  = ov_q;
   assign bus.out_data   = data_q;
   assign bus.err_single = es_q;
   assign bus.err_double = ed_q;
   assign cnt_corr       = corr_q;
   assign cnt_uncorr     = uncorr_q;

   always_comb begin
      single = 1'b0;
      dbl    = 1'b0;
      fixed  = cw_q;
      if (par_q) begin
         if (syn_q == '0) begin
            single = 1'b1;
         end else if (int'(syn_q) <= CW - 1) begin
            single = 1'b1;
            if (ce_q) fixed = cw_q ^ (CW'(1) << syn_q);
         end else begin
            dbl = 1'b1;
         end
      end else if (syn_q != '0) begin
         dbl = 1'b1;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      cw_d       = cw_q;
      syn_d      = syn_q;
      par_d      = par_q;
      ce_d       = ce_q;
      ov_d       = ov_q;
      data_d     = data_q;
      es_d       = es_q;
      ed_d       = ed_q;
      corr_d     = corr_q;
      uncorr_d   = uncorr_q;
      if (adv1) begin
         s1_valid_d = bus.in_valid;
         cw_d       = bus.in_cw;
         syn_d      = syndrome(bus.in_cw);
         par_d      = ^bus.in_cw;
         ce_d       = bus.correct_en;
      end
      // Flags are qualified so an empty slot reads all-zero.
      if (adv2) begin
         ov_d   = s1_valid_q;
         data_d = s1_valid_q ? extract(fixed) : '0;
         es_d   = s1_valid_q && single;
         ed_d   = s1_valid_q && dbl;
      end
      if (cnt_clr) begin
         corr_d   = '0;
         uncorr_d = '0;
      end else if (hs) begin
         if (es_q && corr_q != '1)   corr_d   = corr_q + 1'b1;
         if (ed_q && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         cw_q       <= '0;
         syn_q      <= '0;
         par_q      <= 1'b0;
         ce_q       <= 1'b0;
         ov_q       <= 1'b0;
         data_q     <= '0;
         es_q       <= 1'b0;
         ed_q       <= 1'b0;
         corr_q     <= '0;
         uncorr_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         cw_q       <= cw_d;
         syn_q      <= syn_d;
         par_q      <= par_d;
         ce_q       <= ce_d;
         ov_q       <= ov_d;
         data_q     <= data_d;
         es_q       <= es_d;
         ed_q       <= ed_d;
         corr_q     <= corr_d;
         uncorr_q   <= uncorr_d;
      end
   end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for the SECDED decoder: two instances,
// the second with 2-bit counters for saturation.
module tb_hamming_secded_decoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnt_clr = 1'b0;
   logic        cnt_clr2 = 1'b0;
   logic [15:0] cnt_corr, cnt_uncorr;
   logic [1:0]  c2_corr, c2_uncorr;
   int          checks = 0;
   int          failures = 0;

   // Clean codewords for data 1, 2, 4, 8.
   logic [7:0]  words [4] = '{8'h0F, 8'h33, 8'h55, 8'h96};
   logic [3:0]  wexp  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

   always #5 clk = ~clk;

   hamming_secded_decoder_if #(.DATA_W(4), .PAR_W(3)) bus ();
   hamming_secded_decoder_if #(.DATA_W(4), .PAR_W(3)) bus2 ();

   hamming_secded_decoder #(
      .DATA_W(4), .PAR_W(3), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .cnt_clr(cnt_clr),
      .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
   );

   hamming_secded_decoder #(
      .DATA_W(4), .PAR_W(3), .CNT_W(2)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2),
      .cnt_clr(cnt_clr2),
      .cnt_corr(c2_corr), .cnt_uncorr(c2_uncorr)
   );

   task automatic push(input logic [7:0] cw, input logic ce);
      bus.in_valid   = 1'b1;
      bus.in_cw      = cw;
      bus.correct_en = ce;
      @(posedge clk); #1;
      bus.in_valid   = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.out_data !== 4'h0 || bus.err_single !== 1'b0 ||
          bus.err_double !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs ov=%b rdy=%b d=%h s=%b e=%b exp 0",
                  bus.out_valid, bus.in_ready, bus.out_data,
                  bus.err_single, bus.err_double);
      end
      checks++;
      if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
         failures++;
         $display("FAIL reset_counters corr=%0d uncorr=%0d exp 0",
                  cnt_corr, cnt_uncorr);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b exp 1", bus.in_ready);
      end
   endtask

   task automatic test_clean;
      push(8'hAA, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL clean_latency_early ov=%b exp 0", bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hB ||
          bus.err_single !== 1'b0 || bus.err_double !== 1'b0) begin
         failures++;
         $display("FAIL clean_word ov=%b d=%h s=%b e=%b exp 1/B/0/0",
                  bus.out_valid, bus.out_data,
                  bus.err_single, bus.err_double);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.err_single !== 1'b0 ||
          cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
         failures++;
         $display("FAIL clean_after ov=%b s=%b corr=%0d unc=%0d exp 0",
                  bus.out_valid, bus.err_single, cnt_corr, cnt_uncorr);
      end
   endtask

   task automatic test_single;
      push(8'h8A, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (bus.out_data !== 4'hB || bus.err_single !== 1'b1 ||
          bus.err_double !== 1'b0) begin
         failures++;
         $display("FAIL single_fix d=%h s=%b e=%b exp B/1/0",
                  bus.out_data, bus.err_single, bus.err_double);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_corr !== 16'd1) begin
         failures++;
         $display("FAIL single_cnt got=%0d exp 1", cnt_corr);
      end
      push(8'h8A, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.out_data !== 4'h9 || bus.err_single !== 1'b1 ||
          bus.err_double !== 1'b0) begin
         failures++;
         $display("FAIL single_detect d=%h s=%b e=%b exp 9/1/0",
                  bus.out_data, bus.err_single, bus.err_double);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_corr !== 16'd2) begin
         failures++;
         $display("FAIL single_cnt2 got=%0d exp 2", cnt_corr);
      end
   endtask

   task automatic test_double;
      push(8'hCA, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (bus.out_data !== 4'hD || bus.err_single !== 1'b0 ||
          bus.err_double !== 1'b1) begin
         failures++;
         $display("FAIL double_word d=%h s=%b e=%b exp D/0/1",
                  bus.out_data, bus.err_single, bus.err_double);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_uncorr !== 16'd1 || cnt_corr !== 16'd2) begin
         failures++;
         $display("FAIL double_cnt unc=%0d corr=%0d exp 1/2",
                  cnt_uncorr, cnt_corr);
      end
      push(8'hAB, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (bus.out_data !== 4'hB || bus.err_single !== 1'b1 ||
          bus.err_double !== 1'b0) begin
         failures++;
         $display("FAIL bit0_err d=%h s=%b e=%b exp B/1/0",
                  bus.out_data, bus.err_single, bus.err_double);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_corr !== 16'd3) begin
         failures++;
         $display("FAIL bit0_cnt got=%0d exp 3", cnt_corr);
      end
   endtask

   task automatic test_back_to_back;
      int         sent = 0;
      int         got = 0;
      logic       stalled = 1'b0;
      logic       acc;
      logic       have_hold = 1'b0;
      logic [3:0] hold_d = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         bus.out_ready  = !(cyc >= 3 && cyc < 6);
         bus.correct_en = 1'b1;
         bus.in_valid   = (sent < 4);
         if (sent < 4) bus.in_cw = words[sent];
         @(negedge clk);
         if (!bus.in_ready) stalled = 1'b1;
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid && !bus.out_ready) begin
            if (have_hold) begin
               checks++;
               if (bus.out_data !== hold_d || bus.err_single !== 1'b0 ||
                   bus.err_double !== 1'b0) begin
                  failures++;
                  $display("FAIL b2b_hold d=%h exp %h", bus.out_data, hold_d);
               end
            end
            have_hold = 1'b1;
            hold_d    = bus.out_data;
         end else begin
            have_hold = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.out_data !== wexp[got] || bus.err_single !== 1'b0 ||
                bus.err_double !== 1'b0) begin
               failures++;
               $display("FAIL b2b_word%0d d=%h exp %h", got,
                        bus.out_data, wexp[got]);
            end
            got++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (got != 4 || sent != 4 || !stalled) begin
         failures++;
         $display("FAIL b2b_stream got=%0d sent=%0d stall=%b exp 4/4/1",
                  got, sent, stalled);
      end
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dup ov=%b exp 0", bus.out_valid);
         end
      end
      checks++;
      if (cnt_corr !== 16'd3 || cnt_uncorr !== 16'd1) begin
         failures++;
         $display("FAIL b2b_cnt corr=%0d unc=%0d exp 3/1",
                  cnt_corr, cnt_uncorr);
      end
   endtask

   task automatic test_saturate;
      bus2.out_ready  = 1'b1;
      bus2.correct_en = 1'b1;
      bus2.in_cw      = 8'h8A;
      bus2.in_valid   = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (c2_corr !== 2'd3 || c2_uncorr !== 2'd0) begin
         failures++;
         $display("FAIL sat_cnt corr=%0d unc=%0d exp 3/0",
                  c2_corr, c2_uncorr);
      end
      cnt_clr2 = 1'b1;
      @(posedge clk); #1;
      cnt_clr2 = 1'b0;
      checks++;
      if (c2_corr !== 2'd0) begin
         failures++;
         $display("FAIL sat_clr got=%0d exp 0", c2_corr);
      end
      bus2.in_valid = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (c2_corr !== 2'd1) begin
         failures++;
         $display("FAIL sat_inc got=%0d exp 1", c2_corr);
      end
      bus2.in_valid = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.err_single !== 1'b1) begin
         failures++;
         $display("FAIL sat_word ov=%b s=%b exp 1/1",
                  bus2.out_valid, bus2.err_single);
      end
      cnt_clr2 = 1'b1;
      @(posedge clk); #1;
      cnt_clr2 = 1'b0;
      checks++;
      if (c2_corr !== 2'd0 || bus2.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL sat_clr_inc corr=%0d ov=%b exp 0/0",
                  c2_corr, bus2.out_valid);
      end
   endtask

   task automatic test_reset_midflight;
      bus.out_ready = 1'b0;
      push(8'hAA, 1'b1);
      push(8'h0F, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_full ov=%b rdy=%b exp 1/0",
                  bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 ||
          bus.in_ready !== 1'b0 || cnt_corr !== 16'd0 ||
          cnt_uncorr !== 16'd0) begin
         failures++;
         $display("FAIL mid_reset ov=%b d=%h rdy=%b corr=%0d unc=%0d exp 0",
                  bus.out_valid, bus.out_data, bus.in_ready,
                  cnt_corr, cnt_uncorr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale ov=%b d=%h exp 0",
                     bus.out_valid, bus.out_data);
         end
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_cw       = '0;
      bus.correct_en  = 1'b1;
      bus.out_ready   = 1'b1;
      bus2.in_valid   = 1'b0;
      bus2.in_cw      = '0;
      bus2.correct_en = 1'b1;
      bus2.out_ready  = 1'b1;
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_back_to_back();
      test_saturate();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4: data bits per codeword.
REQ-002 The block SHALL have parameter PAR_W, default 3: Hamming parity bits; the integrator guarantees 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-004 The block SHALL derive local CW = DATA_W+PAR_W+1 (codeword width).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_cw holds a codeword.
REQ-008 in_ready  output  1  block accepts in_cw this cycle.
REQ-009 in_cw  input  CW  codeword: bit 0 = overall parity; bit i (1..CW-1) = Hamming position i.
REQ-010 correct_en  input  1  1 = correct single errors; 0 = detect only; sampled with in_cw.
REQ-011 out_valid  output  1  out_data and flags are valid.
REQ-012 out_ready  input  1  downstream accepts the output.
REQ-013 out_data  output  DATA_W  decoded data.
REQ-014 err_single  output  1  single-bit error detected in this word.
REQ-015 err_double  output  1  uncorrectable error detected in this word.
REQ-016 cnt_clr  input  1  synchronous clear of both counters.
REQ-017 cnt_corr  output  CNT_W  count of delivered words with err_single=1.
REQ-018 cnt_uncorr  output  CNT_W  count of delivered words with err_double=1.

Function
REQ-019 Positions that are powers of two SHALL be parity positions; data bit j SHALL occupy the j-th non-power-of-two position in ascending order.
REQ-020 Syndrome bit k SHALL be the XOR of all positions i (1..CW-1) with bit k of i set; P SHALL be the XOR of all CW bits.
REQ-021 The block SHALL classify: s=0,P=0 no error; P=1,s=0 error in bit 0, data unchanged, err_single=1; P=1, 1<=s<=CW-1: flip position s if correct_en=1, err_single=1; P=1, s>CW-1, or P=0, s!=0: data uncorrected, err_double=1.
REQ-022 With correct_en=0 the block SHALL output the raw extracted data but still raise the flags per REQ-021.
REQ-023 The block SHALL be a 2-stage pipeline: stage 1 registers syndrome, P, raw codeword, correct_en; stage 2 registers out_data and flags.
REQ-024 Latency SHALL be 2 cycles from the accepting edge (in_valid & in_ready) to out_valid=1 when not stalled; throughput one word per cycle.
REQ-025 Stage 2 SHALL advance when !out_valid | out_ready; stage 1 SHALL advance when stage 1 is empty or stage 2 advances; in_ready SHALL equal stage-1 advance.
REQ-026 While out_valid=1 & out_ready=0, out_data, err_single, and err_double SHALL hold stable.
REQ-027 err_single and err_double SHALL never both be 1; both SHALL read 0 when out_valid=0.
REQ-028 Counters SHALL increment only on output handshake (out_valid & out_ready) and saturate at 2^CNT_W-1.
REQ-029 cnt_clr SHALL zero both counters next edge; simultaneous cnt_clr and increment SHALL yield 0.

Reset
REQ-030 rst_n=0 SHALL immediately clear both pipeline valids, out_valid=0, out_data=0, both flags=0, both counters=0; in-flight words SHALL be discarded.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 on the first edge after release.

Verification (DATA_W=4, PAR_W=3)
REQ-032 in_cw=8'hAA, correct_en=1, out_ready=1 -> two cycles later out_data=4'hB, both flags 0, counters unchanged.
REQ-033 in_cw=8'h8A (position 5 flipped) -> out_data=4'hB, err_single=1, cnt_corr=1; same word with correct_en=0 -> out_data=4'h9, err_single=1.
REQ-034 in_cw=8'hCA (positions 5, 6 flipped) -> out_data=4'hD, err_double=1, cnt_uncorr=1; in_cw=8'hAB -> out_data=4'hB, err_single=1.
REQ-035 Back-to-back stream of 4 words, out_ready=0 for 3 cycles mid-stream -> in_ready drops once both stages are full, no word lost or duplicated, order preserved.
REQ-036 CNT_W=2, 5 single-error words -> cnt_corr saturates at 3; cnt_clr asserted on the same cycle as an increment -> cnt_corr=0.
REQ-037 rst_n pulsed low with both stages full -> out_valid=0 immediately, no stale word emitted after release.
